// File: rtl/fe_btb_fetch.sv
`default_nettype none
// ============================================================================
// Module   : fe_btb_fetch
// Purpose  : Fetch-stage PC generator with a direct-mapped branch target
//            buffer and the FE->DE pipeline latch of a 5-stage RV32I core.
// Ports    : clk, reset (sync, active-high)
//            stall_de                          - hold PC and FE latch
//            redirect_valid / redirect_pc      - AGEX redirect
//            upd_valid/pc/target/taken         - AGEX branch resolution
//            imem_addr (out) / imem_rdata (in) - instruction memory
//            fe_valid, fe_inst, fe_pc, fe_pcplus, fe_pred_taken,
//            fe_pred_target, fe_inst_count     - FE->DE latch
// Revision : 1.0 - initial release
// ============================================================================
module fe_btb_fetch #(
    parameter int               DBITS    = 32,
    parameter int               INSTBITS = 32,
    parameter logic [DBITS-1:0] RESET_PC = '0,
    parameter int               BTB_IDX  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_de,
    input  logic                redirect_valid,
    input  logic [DBITS-1:0]    redirect_pc,
    input  logic                upd_valid,
    input  logic [DBITS-1:0]    upd_pc,
    input  logic [DBITS-1:0]    upd_target,
    input  logic                upd_taken,
    output logic [DBITS-1:0]    imem_addr,
    input  logic [INSTBITS-1:0] imem_rdata,
    output logic                fe_valid,
    output logic [INSTBITS-1:0] fe_inst,
    output logic [DBITS-1:0]    fe_pc,
    output logic [DBITS-1:0]    fe_pcplus,
    output logic                fe_pred_taken,
    output logic [DBITS-1:0]    fe_pred_target,
    output logic [DBITS-1:0]    fe_inst_count
);

    localparam int               C_ENTRIES = 1 << BTB_IDX;
    localparam int               C_TAGW    = DBITS - BTB_IDX - 2;
    localparam logic [DBITS-1:0] C_PC_STEP = DBITS'(4);
    localparam logic [1:0]       C_CTR_MAX = 2'b11;
    localparam logic [1:0]       C_CTR_MIN = 2'b00;
    localparam logic [1:0]       C_CTR_NEW = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DBITS-1:0]    pc_q, pc_d;
    logic [DBITS-1:0]    count_q;
    logic                fe_valid_q;
    logic [INSTBITS-1:0] fe_inst_q;
    logic [DBITS-1:0]    fe_pc_q;
    logic [DBITS-1:0]    fe_pcplus_q;
    logic                fe_pred_taken_q;
    logic [DBITS-1:0]    fe_pred_target_q;
    logic [DBITS-1:0]    fe_inst_count_q;

    logic [C_ENTRIES-1:0] btb_valid_q;
    logic [C_TAGW-1:0]    btb_tag_q    [C_ENTRIES];
    logic [DBITS-1:0]     btb_target_q [C_ENTRIES];
    logic [1:0]           btb_ctr_q    [C_ENTRIES];

    // ------------------------------------------------------------------
    // BTB lookup on the current fetch PC (reads pre-update contents)
    // ------------------------------------------------------------------
    logic [BTB_IDX-1:0] w_lk_idx;
    logic [C_TAGW-1:0]  w_lk_tag;
    logic               w_lk_hit;
    logic               w_pred_taken;
    logic [DBITS-1:0]   w_pred_target;
    logic [DBITS-1:0]   w_pc_plus4;

    assign w_lk_idx      = pc_q[BTB_IDX+1:2];
    assign w_lk_tag      = pc_q[DBITS-1:BTB_IDX+2];
    assign w_lk_hit      = btb_valid_q[w_lk_idx] && (btb_tag_q[w_lk_idx] == w_lk_tag);
    assign w_pred_taken  = w_lk_hit && btb_ctr_q[w_lk_idx][1];
    assign w_pred_target = btb_target_q[w_lk_idx];
    assign w_pc_plus4    = pc_q + C_PC_STEP;

    // ------------------------------------------------------------------
    // BTB update side
    // ------------------------------------------------------------------
    logic [BTB_IDX-1:0] w_up_idx;
    logic [C_TAGW-1:0]  w_up_tag;
    logic               w_up_hit;
    logic [1:0]         w_up_ctr_nxt;
    logic               w_unused_upd_lsb;

    assign w_up_idx = upd_pc[BTB_IDX+1:2];
    assign w_up_tag = upd_pc[DBITS-1:BTB_IDX+2];
    assign w_up_hit = btb_valid_q[w_up_idx] && (btb_tag_q[w_up_idx] == w_up_tag);

    // Byte offset of the resolved PC plays no part in indexing or tagging.
    assign w_unused_upd_lsb = ^upd_pc[1:0];

    // Two-bit saturating counter step.
    always_comb begin
        w_up_ctr_nxt = btb_ctr_q[w_up_idx];
        if (upd_taken) begin
            if (btb_ctr_q[w_up_idx] != C_CTR_MAX) begin
                w_up_ctr_nxt = btb_ctr_q[w_up_idx] + 2'b01;
            end
        end else begin
            if (btb_ctr_q[w_up_idx] != C_CTR_MIN) begin
                w_up_ctr_nxt = btb_ctr_q[w_up_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid_q <= '0;
        end else if (upd_valid) begin
            if (w_up_hit) begin
                btb_ctr_q[w_up_idx] <= w_up_ctr_nxt;
                if (upd_taken) begin
                    btb_target_q[w_up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                // Miss on a taken branch: claim the slot, evicting any alias.
                btb_valid_q[w_up_idx]  <= 1'b1;
                btb_tag_q[w_up_idx]    <= w_up_tag;
                btb_target_q[w_up_idx] <= upd_target;
                btb_ctr_q[w_up_idx]    <= C_CTR_NEW;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-PC selection: redirect beats stall beats prediction
    // ------------------------------------------------------------------
    always_comb begin
        pc_d = w_pc_plus4;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall_de) begin
            pc_d = pc_q;
        end else if (w_pred_taken) begin
            pc_d = w_pred_target;
        end
    end

    // ------------------------------------------------------------------
    // PC register, FE latch and sequence counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            count_q          <= '0;
            fe_valid_q       <= 1'b0;
            fe_inst_q        <= '0;
            fe_pc_q          <= '0;
            fe_pcplus_q      <= '0;
            fe_pred_taken_q  <= 1'b0;
            fe_pred_target_q <= '0;
            fe_inst_count_q  <= '0;
        end else begin
            pc_q <= pc_d;
            if (redirect_valid) begin
                // Bubble is written even when DE is stalled; other fields
                // are left as they were since DE ignores them.
                fe_valid_q <= 1'b0;
            end else if (!stall_de) begin
                fe_valid_q       <= 1'b1;
                fe_inst_q        <= imem_rdata;
                fe_pc_q          <= pc_q;
                fe_pcplus_q      <= w_pc_plus4;
                fe_pred_taken_q  <= w_pred_taken;
                fe_pred_target_q <= w_pred_target;
                fe_inst_count_q  <= count_q;
                count_q          <= count_q + DBITS'(1);
            end
        end
    end

    assign imem_addr      = pc_q;
    assign fe_valid       = fe_valid_q;
    assign fe_inst        = fe_inst_q;
    assign fe_pc          = fe_pc_q;
    assign fe_pcplus      = fe_pcplus_q;
    assign fe_pred_taken  = fe_pred_taken_q;
    assign fe_pred_target = fe_pred_target_q;
    assign fe_inst_count  = fe_inst_count_q;

endmodule
`default_nettype wire

// File: doc/fe_btb_fetch.md
# fe_btb_fetch

Fetch-side PC generator and FE latch for the 5-stage RV32I pipeline. It consumes the redirect and branch-resolution updates that the AGEX stage sends to FE. It predicts next-PC with a small direct-mapped branch target buffer (BTB) and drives the instruction-memory address. It also produces the FE→DE latch (valid, inst, PC, PC+4, prediction, instruction count).

## Interface
- DBITS, 32: data/PC width
- INSTBITS, 32: instruction width
- RESET_PC, 32'h0000_0000: PC after reset
- BTB_IDX, 4: log2 of BTB entry count (16 entries)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall_de  in  1  DE cannot accept; hold PC and FE latch
- redirect_valid  in  1  AGEX mispredict/jump resolved; fetch from redirect_pc
- redirect_pc  in  DBITS  correct next PC
- upd_valid  in  1  AGEX resolved a branch/JAL/JALR this cycle
- upd_pc  in  DBITS  PC of resolved instruction
- upd_target  in  DBITS  resolved target
- upd_taken  in  1  resolved direction
- imem_addr  out  DBITS  fetch address (= pc_q)
- imem_rdata  in  INSTBITS  instruction at imem_addr, combinational same cycle
- fe_valid  out  1  latch holds a real instruction
- fe_inst  out  INSTBITS  latched instruction
- fe_pc  out  DBITS  PC of latched instruction
- fe_pcplus  out  DBITS  fe_pc + 4
- fe_pred_taken  out  1  BTB predicted taken
- fe_pred_target  out  DBITS  predicted target (valid when fe_pred_taken)
- fe_inst_count  out  DBITS  sequence number of latched instruction

## Operation
- PC register pc_q; imem_addr = pc_q.
- BTB entry: valid, tag = pc[DBITS-1:BTB_IDX+2], target[DBITS-1:0], 2-bit saturating counter. Index = pc[BTB_IDX+1:2].
- Lookup on pc_q: hit = valid & tag match; pred_taken = hit & ctr[1]; pred_target = entry target.
- Next-PC priority: reset > redirect_valid > stall_de > pred_taken ? pred_target : pc_q+4.
- FE latch update, same priority:
  - redirect_valid: fe_valid←0 (bubble); other fields don't care; count unchanged.
  - stall_de (no redirect): all fe_* hold.
  - otherwise: fe_valid←1, fe_inst←imem_rdata, fe_pc←pc_q, fe_pcplus←pc_q+4, fe_pred_*←lookup, fe_inst_count←count_q; count_q←count_q+1.
- count_q: starts at 0 after reset, 32-bit wraparound (FFFF_FFFF→0).
- BTB update on upd_valid, independent of stall/redirect:
  - Hit at upd_pc: ctr saturating +1 if taken, −1 if not; target←upd_target if taken.
  - Miss, taken: allocate/overwrite: valid=1, tag, target, ctr=2'b10.
  - Miss, not taken: no change.
- Update and lookup on the same index in one cycle: lookup sees pre-update contents; the write is visible from the next cycle.
- All arithmetic mod 2^DBITS; low two PC bits are never checked (AGEX flags misalignment).

## Timing
- Reset values: pc_q=RESET_PC, imem_addr=RESET_PC, fe_valid=0, fe_inst=0, fe_pc=0, fe_pcplus=0, fe_pred_taken=0, fe_pred_target=0, fe_inst_count=0, count_q=0, all BTB valid=0. Reset mid-operation overrides redirect/stall/update in that cycle.
- Fetch latency: 1 cycle; address in cycle N appears in the FE latch after edge N.
- Redirect penalty: the redirect edge latches a bubble and loads redirect_pc. The target instruction is latched on the following edge.
- Redirect and stall_de together: the redirect wins; the bubble is written even though DE is stalled.
- stall_de held for k cycles: the latch and pc_q are frozen for k edges; imem_rdata is re-sampled on release.
- Counter update uses the value before the edge; the predict-taken threshold is ctr≥2.

## Test plan
- Reset then 4 free-run cycles, imem returns 0000_0013 → fe_pc 0,4,8,C; fe_inst_count 0,1,2,3; fe_valid 1 from the first edge after reset.
- redirect_valid=1, redirect_pc=0000_0100 at pc_q=0000_0010 → next cycle fe_valid=0 and imem_addr=0000_0100. The following cycle fe_pc=0000_0100, and the count continues without a gap.
- stall_de=1 for 3 cycles at pc_q=0000_0020 → fe_* and imem_addr are unchanged for 3 edges. The cycle after release latches pc 0000_0020.
- upd_valid, upd_pc=0000_0040, target=0000_0080, taken=1 → when later fetched at 0000_0040, fe_pred_taken=1 and fe_pred_target=0000_0080. The following imem_addr is 0000_0080.
- Train the same entry as not-taken twice (ctr 10→01→00) → fetch at 0000_0040 predicts not-taken and next imem_addr=0000_0044. A further not-taken keeps ctr=00.
- Aliasing: allocate 0000_0040, then taken update at 0000_0440 (same index, different tag) → the entry is overwritten. A fetch at 0000_0040 misses and goes to 0000_0044.
